// File: rtl/alu_share_arbiter_if.sv
// Purpose: bundles the request/response handshakes of both requesters, the
//          shared-ALU drive/sample bus and the busy flag for alu_share_arbiter.
// Signals:
//   reqN_valid/ready/a/b/op      request handshake and operands, requester N
//   rspN_valid/ready/result/zero response handshake and result, requester N
//   alu_a/alu_b/alu_op           registered operands/op to the external ALU
//   alu_result/alu_zero          combinational ALU outputs sampled back
//   busy                         arbiter is not idle
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_zero;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  alu_result, alu_zero,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
        output alu_a, alu_b, alu_op, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output alu_result, alu_zero,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
        input  alu_a, alu_b, alu_op, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: shares one external combinational ALU between two requesters.
//          Round-robin grant, registered operands into the ALU, result
//          captured after one EXEC cycle and held until the response is taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arbiter_if.slave (request/response handshakes, ALU bus, busy)
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_gnt;
    logic             r_last_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_gnt;
    logic             w_idle;
    logic             w_accept;
    logic             w_rsp_hs;

    // Contention goes to the requester that was not served last.
    always_comb begin
        w_gnt = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            w_gnt = ~r_last_gnt;
        else
            w_gnt = bus.req1_valid;
    end

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && (bus.req0_valid || bus.req1_valid);
    assign w_rsp_hs = (r_state == S_RESP) && (r_gnt ? bus.rsp1_ready : bus.rsp0_ready);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_rsp_hs) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_result   <= '0;
            r_zero     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt;
                r_a   <= w_gnt ? bus.req1_a  : bus.req0_a;
                r_b   <= w_gnt ? bus.req1_b  : bus.req0_b;
                r_op  <= w_gnt ? bus.req1_op : bus.req0_op;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_result;
                r_zero   <= bus.alu_zero;
            end
            if (w_rsp_hs)
                r_last_gnt <= r_gnt;
        end
    end

    assign bus.req0_ready  = w_idle && bus.req0_valid && !w_gnt;
    assign bus.req1_ready  = w_idle && bus.req1_valid &&  w_gnt;
    assign bus.rsp0_valid  = (r_state == S_RESP) && !r_gnt;
    assign bus.rsp1_valid  = (r_state == S_RESP) &&  r_gnt;
    assign bus.rsp0_result = r_result;
    assign bus.rsp1_result = r_result;
    assign bus.rsp0_zero   = r_zero;
    assign bus.rsp1_zero   = r_zero;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.alu_op      = r_op;
    assign bus.busy        = !w_idle;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, expected responses queued
// per requester at accept time and checked by an independent monitor.
module tb_alu_share_arbiter;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    exp_t exp0_q[$];
    exp_t exp1_q[$];
    int   gnt_log[$];
    int   gnt_cyc[$];
    bit   seen0;
    bit   seen1;

    alu_share_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU; unknown codes behave as Add.
    always_comb begin
        case (bus.alu_op)
            OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
            OP_SLT:  bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: bus.alu_result = bus.alu_a + bus.alu_b;
        endcase
        bus.alu_zero = (bus.alu_result == 32'd0);
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endfunction

    // Monitor: grant log, mutual exclusion, and scoreboard comparison.
    always @(negedge clk) begin
        if (bus.req0_ready || bus.req1_ready) begin
            gnt_log.push_back(bus.req1_ready ? 1 : 0);
            gnt_cyc.push_back(cyc);
            chk("ready_exclusive", {31'd0, bus.req0_ready && bus.req1_ready}, 32'd0);
        end
        if (bus.rsp0_valid || bus.rsp1_valid)
            chk("rsp_valid_exclusive", {31'd0, bus.rsp0_valid && bus.rsp1_valid}, 32'd0);
        if (bus.rsp0_valid) begin
            if (exp0_q.size() == 0) begin
                chk("rsp0_unexpected", 32'd1, 32'd0);
            end else begin
                if (!seen0) chk("rsp0_latency", 32'(cyc - exp0_q[0].acc), 32'd2);
                seen0 = 1'b1;
                chk("rsp0_result", bus.rsp0_result, exp0_q[0].res);
                chk("rsp0_zero", {31'd0, bus.rsp0_zero}, {31'd0, exp0_q[0].zero});
                if (bus.rsp0_ready) begin
                    void'(exp0_q.pop_front());
                    seen0 = 1'b0;
                end
            end
        end
        if (bus.rsp1_valid) begin
            if (exp1_q.size() == 0) begin
                chk("rsp1_unexpected", 32'd1, 32'd0);
            end else begin
                if (!seen1) chk("rsp1_latency", 32'(cyc - exp1_q[0].acc), 32'd2);
                seen1 = 1'b1;
                chk("rsp1_result", bus.rsp1_result, exp1_q[0].res);
                chk("rsp1_zero", {31'd0, bus.rsp1_zero}, {31'd0, exp1_q[0].zero});
                if (bus.rsp1_ready) begin
                    void'(exp1_q.pop_front());
                    seen1 = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a request and wait (bounded) for its ready; returns #1 after the accept edge.
    task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] eres, input logic ez,
                         input bit push, output int waited);
        bit   got;
        exp_t e;
        got    = 1'b0;
        waited = 0;
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        if (!got) begin
            chk(n == 0 ? "req0_accept_timeout" : "req1_accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.res = eres; e.zero = ez; e.acc = cyc;
            if (n == 0) exp0_q.push_back(e);
            else        exp1_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int n);
        if (n == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    int w;
    int base;
    bit got_v;

    initial begin
        cyc = 0; n_total = 0; n_pass = 0; seen0 = 1'b0; seen1 = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = OP_ADD;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = OP_ADD;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_alu_op", {28'd0, bus.alu_op}, 32'h2);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_result", bus.rsp0_result, 32'd0);
        chk("rst_valids", {28'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
        @(posedge clk); #1;

        // 1: single Add on requester 0
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        issue(0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b1, w);
        drop(0);
        chk("t1_ready_same_cycle", 32'(w), 32'd0);
        chk("t1_busy_exec", {31'd0, bus.busy}, 32'd1);
        repeat (4) @(negedge clk);

        // 2: continuous contention from a fresh reset -> grants 0,1,0,1 every 3 cycles
        do_reset();
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        gnt_log.delete(); gnt_cyc.delete();
        fork
            begin
                int w0;
                issue(0, 32'd1, 32'd2, OP_ADD, 32'd3, 1'b0, 1'b1, w0);
                issue(0, 32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 1'b1, 1'b1, w0);
                drop(0);
            end
            begin
                int w1;
                issue(1, 32'd100, 32'd50, OP_SUB, 32'd50, 1'b0, 1'b1, w1);
                issue(1, 32'd2, 32'd5, OP_SLT, 32'd1, 1'b0, 1'b1, w1);
                drop(1);
            end
        join
        repeat (4) @(negedge clk);
        chk("t2_grant_count", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() == 4) begin
            chk("t2_grant0", 32'(gnt_log[0]), 32'd0);
            chk("t2_grant1", 32'(gnt_log[1]), 32'd1);
            chk("t2_grant2", 32'(gnt_log[2]), 32'd0);
            chk("t2_grant3", 32'(gnt_log[3]), 32'd1);
            for (int i = 1; i < 4; i++)
                chk("t2_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
        end
        @(posedge clk); #1;

        // 3: response held by requester 1 back-pressure; requester 0 blocked meanwhile
        bus.rsp1_ready = 1'b0;
        issue(1, 32'd3, 32'd4, OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b1, w);
        drop(1);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd20; bus.req0_b = 32'd22; bus.req0_op = OP_ADD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t3_req0_blocked", {31'd0, bus.req0_ready}, 32'd0);
        end
        chk("t3_rsp1_held", {31'd0, bus.rsp1_valid}, 32'd1);
        @(posedge clk); #1;
        bus.rsp1_ready = 1'b1;
        issue(0, 32'd20, 32'd22, OP_ADD, 32'd42, 1'b0, 1'b1, w);
        drop(0);
        chk("t3_req0_next_idle", 32'(w), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // 4: op coverage, signed compare, zero flag, pass-through of unknown code
        issue(0, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 1'b0, 1'b1, w); drop(0);
        repeat (2) @(posedge clk); #1;
        issue(0, 32'd9, 32'd9, OP_SUB, 32'd0, 1'b1, 1'b1, w); drop(0);
        repeat (2) @(posedge clk); #1;
        issue(1, 32'h0000_F0F0, 32'h0000_FF00, OP_AND, 32'h0000_F000, 1'b0, 1'b1, w); drop(1);
        repeat (2) @(posedge clk); #1;
        issue(1, 32'h0000_F0F0, 32'h0000_FF00, OP_OR, 32'h0000_FFF0, 1'b0, 1'b1, w); drop(1);
        repeat (2) @(posedge clk); #1;
        issue(0, 32'd10, 32'd20, 4'b1111, 32'd30, 1'b0, 1'b1, w); drop(0);
        chk("t4_op_passthru", {28'd0, bus.alu_op}, 32'hF);
        chk("t4_alu_a", bus.alu_a, 32'd10);
        repeat (3) @(posedge clk); #1;

        // 5: reset while in EXEC discards the transaction
        issue(0, 32'd5, 32'd3, OP_SUB, 32'd2, 1'b0, 1'b0, w);
        drop(0);
        chk("t5_alu_op_pre", {28'd0, bus.alu_op}, 32'h6);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_alu_op", {28'd0, bus.alu_op}, 32'h2);
        chk("t5_alu_a", bus.alu_a, 32'd0);
        chk("t5_valids", {28'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_idle_after", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;

        // 6: one-cycle request during RESP is never accepted
        bus.rsp1_ready = 1'b0;
        issue(1, 32'd7, 32'd8, OP_ADD, 32'd15, 1'b0, 1'b1, w);
        drop(1);
        got_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp1_valid) begin got_v = 1'b1; break; end
        end
        chk("t6_rsp1_seen", {31'd0, got_v}, 32'd1);
        base = gnt_log.size();
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = OP_ADD;
        @(negedge clk);
        chk("t6_req0_not_ready", {31'd0, bus.req0_ready}, 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.rsp1_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_no_accept", 32'(gnt_log.size()), 32'(base));

        // Drain
        for (int i = 0; i < 20 && (exp0_q.size() != 0 || exp1_q.size() != 0); i++)
            @(negedge clk);
        chk("drain_q0", 32'(exp0_q.size()), 32'd0);
        chk("drain_q1", 32'(exp1_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
